// File: rtl/microsequencer_if.sv
// Sequencing fields, status inputs and sequencer outputs shared by the microsequencer and its driver.
// The master side drives the microinstruction fields; the slave side is the sequencer.
interface microsequencer_if #(
  parameter int unsigned AW = 7
);
  logic [2:0]    ns_ctl;
  logic [AW-1:0] cr_addr;
  logic [1:0]    cond_sel;
  logic          cond_inv;
  logic [3:0]    cond;
  logic [AW-1:0] dec_addr;
  logic          mfc;
  logic          hold;
  logic [AW-1:0] index;
  logic          in_wait;
  logic          wait_to;
  logic          stk_err;

  modport master (
    output ns_ctl, cr_addr, cond_sel, cond_inv, cond, dec_addr, mfc, hold,
    input  index, in_wait, wait_to, stk_err
  );

  modport slave (
    input  ns_ctl, cr_addr, cond_sel, cond_inv, cond, dec_addr, mfc, hold,
    output index, in_wait, wait_to, stk_err
  );
endinterface

// File: rtl/microsequencer.sv
// Microprogram sequencer: registers the microstore index and picks the next one every clock.
// Define MICROSEQ_RETSTACK_EN to build the CALL/RET return-address stack.
module microsequencer #(
  parameter int unsigned   AW          = 7,
  parameter int unsigned   STACK_DEPTH = 4,
  parameter int unsigned   WAIT_MAX    = 255,
  parameter logic [AW-1:0] FAULT_ADDR  = 'h5A
) (
  input logic             clk,
  input logic             reset_n,
  microsequencer_if.slave bus
);
  typedef enum logic [2:0] {
    NS_INC    = 3'b000,
    NS_JUMP   = 3'b001,
    NS_DECODE = 3'b010,
    NS_CBR    = 3'b011,
    NS_WAIT   = 3'b100,
    NS_CALL   = 3'b101,
    NS_RET    = 3'b110,
    NS_RST    = 3'b111
  } ns_e;

  if (STACK_DEPTH < 2 || STACK_DEPTH > 8 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0 ||
      WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_cfg
    $error("microsequencer: unsupported STACK_DEPTH or WAIT_MAX");
  end

  ns_e           ns;
  logic [AW-1:0] index_q, index_d, inc;
  logic [7:0]    wcnt_q, wcnt_d;
  logic          wait_to_q, wait_to_d;
  logic          cond_hit;

  assign ns       = ns_e'(bus.ns_ctl);
  assign inc      = index_q + AW'(1);
  assign cond_hit = bus.cond[bus.cond_sel] ^ bus.cond_inv;

`ifdef MICROSEQ_RETSTACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH);
  localparam int CNT_W = SP_W + 1;

  // sp_q is the next write slot; entries below it (mod depth) are the live stack.
  logic [AW-1:0]    stack_q [STACK_DEPTH];
  logic [SP_W-1:0]  sp_q, top_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             push, pop, stk_full, stk_empty;
  logic             stk_err_q, stk_err_d;

  assign top_ptr   = sp_q - SP_W'(1);
  assign stk_full  = (cnt_q == CNT_W'(STACK_DEPTH));
  assign stk_empty = (cnt_q == '0);
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    index_d   = inc;
    wcnt_d    = '0;
    wait_to_d = wait_to_q;
`ifdef MICROSEQ_RETSTACK_EN
    stk_err_d = stk_err_q;
    push      = 1'b0;
    pop       = 1'b0;
`endif
    unique case (ns)
      NS_INC:    index_d = inc;
      NS_JUMP:   index_d = bus.cr_addr;
      NS_DECODE: index_d = bus.dec_addr;
      NS_CBR:    index_d = cond_hit ? bus.cr_addr : inc;
      NS_WAIT: begin
        if (!bus.mfc) begin
          if (wcnt_q == 8'(WAIT_MAX - 1)) begin
            index_d   = FAULT_ADDR;
            wait_to_d = 1'b1;
          end else begin
            index_d = index_q;
            wcnt_d  = wcnt_q + 8'd1;
          end
        end
      end
`ifdef MICROSEQ_RETSTACK_EN
      NS_CALL: begin
        index_d = bus.cr_addr;
        push    = 1'b1;
        if (stk_full) stk_err_d = 1'b1;
      end
      NS_RET: begin
        if (stk_empty) begin
          index_d   = '0;
          stk_err_d = 1'b1;
        end else begin
          index_d = stack_q[top_ptr];
          pop     = 1'b1;
        end
      end
`else
      NS_CALL:   index_d = bus.cr_addr;
      NS_RET:    index_d = '0;
`endif
      NS_RST:    index_d = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_q   <= '0;
      wcnt_q    <= '0;
      wait_to_q <= 1'b0;
    end else if (!bus.hold) begin
      index_q   <= index_d;
      wcnt_q    <= wcnt_d;
      wait_to_q <= wait_to_d;
    end
  end

`ifdef MICROSEQ_RETSTACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q      <= '0;
      cnt_q     <= '0;
      stk_err_q <= 1'b0;
    end else if (!bus.hold) begin
      stk_err_q <= stk_err_d;
      if (push) begin
        sp_q <= sp_q + SP_W'(1);
        if (!stk_full) cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop) begin
        sp_q  <= top_ptr;
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // NOTE: the stack array has no reset; clearing cnt_q is what discards its contents.
  always_ff @(posedge clk) begin
    if (!bus.hold && push) stack_q[sp_q] <= inc;
  end

  assign bus.stk_err = stk_err_q;
`else
  assign bus.stk_err = 1'b0;
`endif

  assign bus.index   = index_q;
  assign bus.in_wait = (ns == NS_WAIT);
  assign bus.wait_to = wait_to_q;
endmodule

// File: doc/microsequencer.md
# microsequencer

Microprogram sequencer for the microprogrammed control unit: holds the 7-bit microstore index register and computes the next index every clock from the sequencing fields of the current microinstruction. It sits directly upstream of the microstore ROM, driving its address input. It consumes the ROM's next-address fields, instruction-decoder dispatch address, condition flags and memory-complete handshake. It provides increment, jump, decode dispatch, conditional branch, memory-wait with timeout, and a small return-address stack.

## Interface
- AW, 7, index width (ROM depth 2^AW)
- STACK_DEPTH, 4, return-stack entries (power of two, 2..8)
- WAIT_MAX, 255, max cycles in WAIT before timeout (1..255)
- FAULT_ADDR, 7'h5A, index taken on wait timeout
---
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ns_ctl  in  3  next-address type from current microinstruction
- cr_addr  in  AW  branch/jump target from current microinstruction
- cond_sel  in  2  selects one bit of cond
- cond_inv  in  1  inverts selected condition
- cond  in  4  condition inputs (condition tester, flags)
- dec_addr  in  AW  dispatch address from instruction decoder
- mfc  in  1  memory function complete
- hold  in  1  external stall; freezes all state
- index  out  AW  registered microstore address
- in_wait  out  1  high while current ns_ctl is WAIT (combinational)
- wait_to  out  1  sticky: wait timeout occurred
- stk_err  out  1  sticky: stack overflow/underflow

## Operation
- c = cond[cond_sel] ^ cond_inv; inc = index+1 mod 2^AW (127 wraps to 0).
- ns_ctl decode (next index):
  - 000 INC: inc
  - 001 JUMP: cr_addr
  - 010 DECODE: dec_addr
  - 011 CBR: c ? cr_addr : inc
  - 100 WAIT: mfc ? inc : (wcnt==WAIT_MAX-1 ? FAULT_ADDR, set wait_to : index, wcnt++)
  - 101 CALL: push inc, go cr_addr
  - 110 RET: pop, go popped value
  - 111 RST: 0
- wcnt (8-bit) clears on any cycle where index changes or ns_ctl≠WAIT.
- Stack: circular buffer, pointer + count. CALL when full: oldest entry overwritten, stk_err set, count stays STACK_DEPTH. RET when empty: next index 0, stk_err set.
- hold=1: index, wcnt, stack, sticky flags all unchanged; mfc that cycle ignored.
- Sticky flags clear only on reset.

## Timing
- Reset (async assert, sync-style release on next edge): index=0, wcnt=0, stack count=0, wait_to=0, stk_err=0.
- One-cycle sequencing: ROM is combinational, so fields reflect current index; new index valid after each rising edge.
- WAIT with mfc on entry cycle: zero stall cycles. mfc and timeout in same cycle: mfc wins, no wait_to.
- WAIT_MAX=N: with mfc never asserted, index holds N cycles then becomes FAULT_ADDR.
- Reset mid-WAIT or mid-call-chain: all state discarded immediately.

## Configuration
- MICROSEQ_RETSTACK_EN defined: CALL/RET as above, stack instantiated.
- Undefined: no stack storage; CALL acts as JUMP, RET acts as RST, stk_err tied 0.

## Test plan
- Reset, hold ns_ctl=INC 130 cycles -> index 0,1,…,127,0,1; flags 0.
- index=5, ns_ctl=CBR, cr_addr=40, cond=4'b0100, cond_sel=2, cond_inv=0 -> index 40; cond_inv=1 -> index 6.
- ns_ctl=WAIT at index 10, mfc raised on 3rd cycle -> index 10 for 3 cycles then 11, in_wait high throughout; mfc never raised, WAIT_MAX=255 -> index 0x5A after 255 cycles, wait_to=1.
- CALL 20 from index 3, CALL 50 from 20, RET, RET -> index 20,50,21,4; stk_err 0.
- 5 CALLs with STACK_DEPTH=4 -> stk_err=1; then 5 RETs -> last four return newest-first, fifth goes to 0.
- hold=1 during WAIT with mfc=1 -> index/wcnt frozen; reset_n low mid-WAIT -> index=0 immediately, wait_to=0.
